// File: rtl/bsk_pkg.sv
// Shared definitions for the discrete-input scanner: bank encodings, bus width
// and the active-low bus to active-high command conversion.
package bsk_pkg;

  localparam int unsigned BUS_W = 16;

  typedef enum logic {
    BANK_PRD = 1'b0,
    BANK_PRM = 1'b1
  } bank_e;

  function automatic logic [BUS_W-1:0] bus_to_cmd(input logic [BUS_W-1:0] bus);
    return ~bus;
  endfunction

endpackage

// File: rtl/bsk_in_scan_if.sv
// Scanner-side signal bundle: shared input bus, buffer enables and debounced words.
interface bsk_in_scan_if;
  import bsk_pkg::*;

  logic [BUS_W-1:0] iBus;
  logic             oOePrd;
  logic             oOePrm;
  logic [BUS_W-1:0] oDataPrd;
  logic [BUS_W-1:0] oDataPrm;
  logic             oUpd;
  logic             oReady;

  modport master (
    input  iBus,
    output oOePrd,
    output oOePrm,
    output oDataPrd,
    output oDataPrm,
    output oUpd,
    output oReady
  );

  modport slave (
    output iBus,
    input  oOePrd,
    input  oOePrm,
    input  oDataPrd,
    input  oDataPrm,
    input  oUpd,
    input  oReady
  );

endinterface

// File: rtl/bsk_in_deb.sv
// One-bank debouncer: captures a sample, counts identical consecutive samples and
// publishes the value once it has been seen DEB_CNT times in a row.
module bsk_in_deb import bsk_pkg::*; #(
  parameter int unsigned DEB_CNT = 3
) (
  input  logic             clk,
  input  logic             iRst,
  input  logic             iSample,
  input  logic             iEval,
  input  logic [BUS_W-1:0] iData,
  output logic [BUS_W-1:0] oOut,
  output logic             oChg,
  output logic             oAcc
);

  localparam int unsigned MW = $clog2(DEB_CNT + 1);
  localparam logic [MW-1:0] DebMax = MW'(DEB_CNT);

  logic [BUS_W-1:0] r_sample;
  logic [BUS_W-1:0] r_last;
  logic [BUS_W-1:0] r_out;
  logic [MW-1:0]    r_match;

  logic [MW-1:0]    w_match_new;
  logic             w_acc;
  logic             w_chg;

  // The new 'last' is always the sample: either it already equals last or replaces it.
  always_comb begin
    w_match_new = MW'(1);
    if (r_sample == r_last) begin
      w_match_new = (r_match == DebMax) ? DebMax : r_match + 1'b1;
    end
    w_acc = iEval && (w_match_new == DebMax);
    w_chg = w_acc && (r_sample != r_out);
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      r_sample <= '0;
      r_last   <= '0;
      r_match  <= '0;
      r_out    <= '0;
    end else begin
      if (iSample) begin
        r_sample <= iData;
      end
      if (iEval) begin
        r_last  <= r_sample;
        r_match <= w_match_new;
        if (w_chg) begin
          r_out <= r_sample;
        end
      end
    end
  end

  assign oOut = r_out;
  assign oChg = w_chg;
  assign oAcc = w_acc;

endmodule

// File: rtl/bsk_in_scan.sv
// Multiplexed discrete-input scanner: alternates the PRD/PRM buffers on a shared
// active-low bus, samples each bank once per slot and debounces it.
module bsk_in_scan import bsk_pkg::*; #(
  parameter int unsigned CNT_MAX = 10,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned DEB_CNT = 3
) (
  input  logic         clk,
  input  logic         iRst,
  bsk_in_scan_if.master io_scan
);

  localparam int unsigned CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CntLast = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CntSamp = CW'(CNT_MAX - 2);

  if (CNT_MAX < SETTLE + 3) begin : g_bad_cnt_max
    $error("CNT_MAX must be at least SETTLE+3");
  end
  if (DEB_CNT < 1) begin : g_bad_deb_cnt
    $error("DEB_CNT must be at least 1");
  end

  logic [CW-1:0]    r_cnt;
  bank_e            r_bank;
  logic             r_oe_prd;
  logic             r_oe_prm;
  logic             r_upd;
  logic             r_seen_prd;
  logic             r_seen_prm;
  logic             r_ready;

  logic [CW-1:0]    w_cnt_next;
  bank_e            w_bank_next;
  logic             w_oe_next;
  logic             w_smp_prd;
  logic             w_smp_prm;
  logic             w_eval_prd;
  logic             w_eval_prm;
  logic [BUS_W-1:0] w_cmd;
  logic [BUS_W-1:0] w_out_prd;
  logic [BUS_W-1:0] w_out_prm;
  logic             w_chg_prd;
  logic             w_chg_prm;
  logic             w_acc_prd;
  logic             w_acc_prm;

  // Enables are computed from the next slot position so they come out of a flop.
  always_comb begin
    w_cnt_next  = (r_cnt == CntLast) ? '0 : r_cnt + 1'b1;
    w_bank_next = r_bank;
    if (r_cnt == CntLast) begin
      w_bank_next = (r_bank == BANK_PRD) ? BANK_PRM : BANK_PRD;
    end
    w_oe_next  = (w_cnt_next != '0) && (w_cnt_next != CntLast);
    w_smp_prd  = (r_cnt == CntSamp) && (r_bank == BANK_PRD);
    w_smp_prm  = (r_cnt == CntSamp) && (r_bank == BANK_PRM);
    w_eval_prd = (r_cnt == CntLast) && (r_bank == BANK_PRD);
    w_eval_prm = (r_cnt == CntLast) && (r_bank == BANK_PRM);
    w_cmd      = bus_to_cmd(io_scan.iBus);
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      r_cnt      <= '0;
      r_bank     <= BANK_PRD;
      r_oe_prd   <= 1'b0;
      r_oe_prm   <= 1'b0;
      r_upd      <= 1'b0;
      r_seen_prd <= 1'b0;
      r_seen_prm <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_bank     <= w_bank_next;
      r_oe_prd   <= w_oe_next && (w_bank_next == BANK_PRD);
      r_oe_prm   <= w_oe_next && (w_bank_next == BANK_PRM);
      r_upd      <= w_chg_prd | w_chg_prm;
      r_seen_prd <= r_seen_prd | w_acc_prd;
      r_seen_prm <= r_seen_prm | w_acc_prm;
      r_ready    <= r_ready | ((r_seen_prd | w_acc_prd) & (r_seen_prm | w_acc_prm));
    end
  end

  bsk_in_deb #(
    .DEB_CNT (DEB_CNT)
  ) u_deb_prd (
    .clk     (clk),
    .iRst    (iRst),
    .iSample (w_smp_prd),
    .iEval   (w_eval_prd),
    .iData   (w_cmd),
    .oOut    (w_out_prd),
    .oChg    (w_chg_prd),
    .oAcc    (w_acc_prd)
  );

  bsk_in_deb #(
    .DEB_CNT (DEB_CNT)
  ) u_deb_prm (
    .clk     (clk),
    .iRst    (iRst),
    .iSample (w_smp_prm),
    .iEval   (w_eval_prm),
    .iData   (w_cmd),
    .oOut    (w_out_prm),
    .oChg    (w_chg_prm),
    .oAcc    (w_acc_prm)
  );

  assign io_scan.oOePrd   = r_oe_prd;
  assign io_scan.oOePrm   = r_oe_prm;
  assign io_scan.oDataPrd = w_out_prd;
  assign io_scan.oDataPrm = w_out_prm;
  assign io_scan.oUpd     = r_upd;
  assign io_scan.oReady   = r_ready;

endmodule

// File: tb/tb_bsk_in_scan.sv
// Directed bench for bsk_in_scan: default instance plus a CNT_MAX=5/DEB_CNT=1 corner.
module tb_bsk_in_scan;
  import bsk_pkg::*;

  logic clk = 1'b0;
  logic iRst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] prd_val = 16'hFFFF;
  logic [15:0] prm_val = 16'hFFFF;
  logic [15:0] prd5_val = 16'hFFFF;
  logic [15:0] prm5_val = 16'hFFFF;

  bsk_in_scan_if sif ();
  bsk_in_scan_if sif5 ();

  // Model of the two tri-state buffers with bus pull-ups when neither is enabled.
  assign sif.iBus  = sif.oOePrd  ? prd_val  : (sif.oOePrm  ? prm_val  : 16'hFFFF);
  assign sif5.iBus = sif5.oOePrd ? prd5_val : (sif5.oOePrm ? prm5_val : 16'hFFFF);

  bsk_in_scan #(
    .CNT_MAX (10),
    .SETTLE  (2),
    .DEB_CNT (3)
  ) u_dut (
    .clk     (clk),
    .iRst    (iRst),
    .io_scan (sif)
  );

  bsk_in_scan #(
    .CNT_MAX (5),
    .SETTLE  (2),
    .DEB_CNT (1)
  ) u_dut5 (
    .clk     (clk),
    .iRst    (iRst),
    .io_scan (sif5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] bounce [5] = '{16'hFFFD, 16'hFFFE, 16'hFFFD, 16'hFFFD, 16'hFFFD};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    iRst = 1'b0;
    cyc  = 0;
  endtask

  initial begin
    int m;
    logic [15:0] tmp;

    // Enable pattern and basic acceptance.
    prd_val = 16'hFFFE;
    prm_val = 16'hFF00;
    do_reset();
    chk("reset_oe_prd", 32'(sif.oOePrd), 32'd0);
    chk("reset_data_prd", 32'(sif.oDataPrd), 32'd0);
    chk("reset_ready", 32'(sif.oReady), 32'd0);
    for (int c = 0; c < 100; c++) begin
      m = c % 20;
      chk("oe_prd", 32'(sif.oOePrd), 32'(m >= 1 && m <= 8));
      chk("oe_prm", 32'(sif.oOePrm), 32'(m >= 11 && m <= 18));
      chk("oe_overlap", 32'(sif.oOePrd & sif.oOePrm), 32'd0);
      chk("basic_prd", 32'(sif.oDataPrd), (c >= 50) ? 32'h0001 : 32'h0);
      chk("basic_prm", 32'(sif.oDataPrm), (c >= 60) ? 32'h00FF : 32'h0);
      chk("basic_upd", 32'(sif.oUpd), 32'(c == 50 || c == 60));
      chk("basic_ready", 32'(sif.oReady), 32'(c >= 60));
      next_cycle();
    end

    // Bounce rejection on PRD slots 10,12,14,16,18.
    for (int c = 100; c < 200; c++) begin
      if ((c % 20) == 0) begin
        tmp = bounce[(c - 100) / 20];
        prd_val = tmp;
      end
      chk("bounce_prd", 32'(sif.oDataPrd), (c >= 190) ? 32'h0002 : 32'h0001);
      chk("bounce_prm", 32'(sif.oDataPrm), 32'h00FF);
      chk("bounce_upd", 32'(sif.oUpd), 32'(c == 190));
      next_cycle();
    end

    // Reset after acceptance clears everything.
    iRst = 1'b1;
    next_cycle();
    iRst = 1'b0;
    cyc  = 0;
    chk("rst2_data_prd", 32'(sif.oDataPrd), 32'h0);
    chk("rst2_data_prm", 32'(sif.oDataPrm), 32'h0);
    chk("rst2_ready", 32'(sif.oReady), 32'd0);

    // No-change acceptance.
    prd_val = 16'hFFFF;
    prm_val = 16'hFFFF;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      chk("nochg_prd", 32'(sif.oDataPrd), 32'h0);
      chk("nochg_prm", 32'(sif.oDataPrm), 32'h0);
      chk("nochg_upd", 32'(sif.oUpd), 32'd0);
      chk("nochg_ready", 32'(sif.oReady), 32'(c >= 60));
      next_cycle();
    end

    // Mid-slot reset at cycle 34 (PRM slot, enable high).
    prd_val = 16'hFFFE;
    prm_val = 16'hFF00;
    do_reset();
    repeat (34) next_cycle();
    chk("mid_pre_oe_prm", 32'(sif.oOePrm), 32'd1);
    iRst = 1'b1;
    next_cycle();
    iRst = 1'b0;
    cyc  = 0;
    chk("mid_oe_prd", 32'(sif.oOePrd), 32'd0);
    chk("mid_oe_prm", 32'(sif.oOePrm), 32'd0);
    chk("mid_data_prd", 32'(sif.oDataPrd), 32'h0);
    chk("mid_data_prm", 32'(sif.oDataPrm), 32'h0);
    chk("mid_ready", 32'(sif.oReady), 32'd0);
    for (int c = 0; c < 61; c++) begin
      m = c % 20;
      chk("mid_oe_prd_seq", 32'(sif.oOePrd), 32'(m >= 1 && m <= 8));
      chk("mid_oe_prm_seq", 32'(sif.oOePrm), 32'(m >= 11 && m <= 18));
      chk("mid_data_prd_seq", 32'(sif.oDataPrd), (c >= 50) ? 32'h0001 : 32'h0);
      chk("mid_ready_seq", 32'(sif.oReady), 32'(c >= 60));
      next_cycle();
    end

    // Parameter corner: CNT_MAX=5, DEB_CNT=1.
    prd5_val = 16'hFFF0;
    prm5_val = 16'h0FFF;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      m = c % 10;
      chk("c5_oe_prd", 32'(sif5.oOePrd), 32'(m >= 1 && m <= 3));
      chk("c5_oe_prm", 32'(sif5.oOePrm), 32'(m >= 6 && m <= 8));
      chk("c5_data_prd", 32'(sif5.oDataPrd), (c >= 5) ? 32'h000F : 32'h0);
      chk("c5_data_prm", 32'(sif5.oDataPrm), (c >= 10) ? 32'hF000 : 32'h0);
      chk("c5_upd", 32'(sif5.oUpd), 32'(c == 5 || c == 10));
      chk("c5_ready", 32'(sif5.oReady), 32'(c >= 10));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsk_in_scan.md
# bsk_in_scan

Multiplexed discrete-input scanner: the read-side counterpart of the command indication driver. One shared 16-bit input bus is fed by two tri-state buffers, the transmitter command inputs (PRD) and the receiver command inputs (PRM). The block alternately enables each buffer, samples the bus, debounces each bank, and presents two stable 16-bit command words to the control logic. It sits next to the LED multiplexer on the same front-panel/command board timing scheme.

## Interface

- CNT_MAX, 10: cycles per scan slot; must be at least SETTLE+3.
- SETTLE, 2: cycles of bus settling after buffer enable before sampling is legal.
- DEB_CNT, 3: consecutive identical samples of a bank required to accept a new value; must be at least 1.

- clk  in  1  system clock.
- Reset: one clock; reset is synchronous and active-high; port name `iRst`.
- iBus  in  16  shared input bus, active-low: 0 = command present.
- oOePrd  out  1  PRD buffer output enable, active-high.
- oOePrm  out  1  PRM buffer output enable, active-high.
- oDataPrd  out  16  debounced PRD commands, active-high: `~iBus`.
- oDataPrm  out  16  debounced PRM commands, active-high.
- oUpd  out  1  one-cycle pulse in the cycle after either data output changes value.
- oReady  out  1  high once both banks have accepted at least one value. Sticky until reset.

## Operation

- Slot counter `cnt` runs 0..CNT_MAX-1, then wraps to 0. Bank select toggles PRD→PRM→PRD at each wrap.
- The enable for the selected bank is high for `cnt` in 1..CNT_MAX-2. Both enables are low at `cnt`=0 and `cnt`=CNT_MAX-1, which gives a bus-turnaround gap. oOePrd and oOePrm are never high together.
- Sample: at the edge ending `cnt`=CNT_MAX-2, register `~iBus` into the sample register of the selected bank.
- Debounce, per bank, at the edge ending `cnt`=CNT_MAX-1 of that bank's slot:
  - If sample == last: match <= min(match+1, DEB_CNT).
  - Otherwise: last <= sample and match <= 1.
- Accept: when the new match equals DEB_CNT, the bank is accepted. If `last` differs from the bank output, the output takes `last` and oUpd is pulsed at that same edge.
- With DEB_CNT=1, every differing sample is accepted immediately.
- oReady is set at the edge where the second bank is accepted for the first time. A value of 0 counts as accepted.
- Reset, at any point including mid-slot:
  - `cnt`=0, bank=PRD, both enables 0.
  - Data outputs 0, oUpd 0, oReady 0.
  - Per-bank last=0 and match=0.
- Each bank's state is touched only in its own slot. The other bank holds its state.

## Timing

- All outputs are registered. There is no combinational path from iBus to any output.
- Cycle 0 is the first cycle with iRst low. Slot k occupies cycles 10k..10k+9 with the default parameters. Even k is PRD, odd k is PRM.
- oOePrd is high in cycles 10k+1..10k+8 for even k.
- iBus is sampled at the end of cycle 10k+8. The output update is visible from cycle 10k+10. oUpd is high in cycle 10k+10 only.
- Latency from a bus change to the output is up to (2·DEB_CNT)·CNT_MAX + CNT_MAX cycles. Glitches shorter than one sample are invisible unless they coincide with a sample edge.
- With a constant bus from reset, the earliest PRD update is visible at cycle 50 and the earliest PRM update at cycle 60. oReady is high from cycle 60.

## Structure

- Shared package `bsk_pkg`: bank encodings BANK_PRD=1'b0 and BANK_PRM=1'b1, and the width constant BUS_W=16.
- Counter width is `$clog2(CNT_MAX)`. Match counter width is `$clog2(DEB_CNT+1)`.
- Sub-module `bsk_in_deb`: a one-bank 16-bit debouncer holding sample, last, match and out.
  - Inputs: `iSample` strobe, `iEval` strobe, data.
  - Outputs: `oOut`, `oChg`, `oAcc`.
  - Instantiated twice. The top level holds the slot counter, enables, oUpd (OR of `oChg`) and oReady.

## Test plan

- Enable pattern: reset, then run 100 cycles. Check:
  - oOePrd is high exactly in cycles 1–8, 21–28, …
  - oOePrm is high in 11–18, 31–38, …
  - The two enables never overlap.
- Basic acceptance: drive iBus=16'hFFFE while oOePrd is high and 16'hFF00 while oOePrm is high. Check:
  - oDataPrd=16'h0001 and an oUpd pulse at cycle 50.
  - oDataPrm=16'h00FF and an oUpd pulse at cycle 60.
  - oReady rises at 60.
- Bounce rejection: after the PRD bank is stable at 16'h0001, present PRD bus values 16'hFFFD, 16'hFFFE, 16'hFFFD, 16'hFFFD, 16'hFFFD in consecutive PRD slots. Check oDataPrd stays 16'h0001 until the third consecutive 16'hFFFD sample, then changes to 16'h0002 with one oUpd.
- No-change acceptance: with an all-ones bus from reset, check outputs stay 0, oUpd never pulses, and oReady rises at cycle 60.
- Mid-slot reset: assert iRst at cycle 34 for one cycle. Check that in the next cycle:
  - Both enables are 0, outputs are 0 and oReady is 0.
  - The scan restarts with PRD in slot 0.
- Parameter corner: CNT_MAX=5, SETTLE=2, DEB_CNT=1. Check enables are high for `cnt`=1..3 and each bank updates in its first slot (PRD visible at cycle 5, PRM at cycle 10).
